eth_mii_tx: RTL



---
 rtl/eth_pkg.sv | 13 +
 rtl/eth_crc32_byte.sv | 16 +
 rtl/eth_mii_tx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared constants and state encoding for the Ethernet MII datapath.
package eth_pkg;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_HI       = 4'hD;
  localparam int          MIN_FRAME    = 60;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_POLY_R   = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG} tx_state_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational CRC-32 (reflected 0xEDB88320) advance by one byte, LSB first.
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY_R) : (crc_out >> 1);
  end

endmodule

// File: rtl/eth_mii_tx.sv
// MII transmit MAC: preamble/SFD, payload from TX RAM, FCS, inter-frame gap.
// Define ETH_TX_PAD_EN to zero-pad frames shorter than MIN_FRAME bytes.
module eth_mii_tx
  import eth_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int MAX_LEN = 1514,
  parameter int IFG_NIB = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [7:0]        buf_data,
  output logic [3:0]        mii_txd,
  output logic              mii_tx_en,
  output logic              mii_tx_er
);

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [7:0]  IFG_W     = 8'(IFG_NIB);
`ifdef ETH_TX_PAD_EN
  localparam logic [15:0] MIN_W     = 16'(MIN_FRAME);
`endif

  tx_state_t         state;
  logic [15:0]       len_q, byte_idx, nxt_idx;
  logic [7:0]        cnt;
  logic              hi_phase;
  logic [3:0]        hi_nib;
  logic [31:0]       crc, crc_nxt, fcs;
  logic [7:0]        crc_din;
  logic              len_ok;
  logic [ADDR_W-1:0] addr_nxt;

  assign mii_tx_er = 1'b0;
  assign len_ok    = (len != 16'd0) && (len <= MAX_LEN_W);
  assign nxt_idx   = byte_idx + 16'd1;
  assign fcs       = ~crc;

  // Address of byte k+1 is issued when byte k is loaded, giving the RAM two
  // cycles; it never advances past len-1.
  assign addr_nxt  = (nxt_idx < len_q) ? ADDR_W'(nxt_idx) : buf_addr;

  // Bytes past the payload are pad bytes and contribute zeros to the CRC.
  assign crc_din   = (byte_idx >= len_q) ? 8'h00 : buf_data;

  eth_crc32_byte u_crc (
    .crc_in  (crc),
    .data    (crc_din),
    .crc_out (crc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mii_tx_en <= 1'b0;
      mii_txd   <= 4'h0;
      buf_addr  <= '0;
      crc       <= CRC_INIT;
      len_q     <= 16'd0;
      byte_idx  <= 16'd0;
      cnt       <= 8'd0;
      hi_phase  <= 1'b0;
      hi_nib    <= 4'h0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              state     <= PRE;
              busy      <= 1'b1;
              mii_tx_en <= 1'b1;
              mii_txd   <= PREAMBLE_NIB;
              cnt       <= 8'd1;
              len_q     <= len;
              buf_addr  <= '0;
              byte_idx  <= 16'd0;
              crc       <= CRC_INIT;
              hi_phase  <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end

        PRE: begin
          if (cnt == 8'd15) begin
            state   <= SFD;
            mii_txd <= SFD_HI;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        // SFD shares the byte-load path: its single cycle loads byte 0.
        SFD, DATA: begin
          if (hi_phase) begin
            mii_txd  <= hi_nib;
            hi_phase <= 1'b0;
          end else if (state == DATA && byte_idx == len_q) begin
`ifdef ETH_TX_PAD_EN
            if (byte_idx < MIN_W) begin
              state    <= PAD;
              mii_txd  <= 4'h0;
              crc      <= crc_nxt;
              hi_phase <= 1'b1;
              byte_idx <= nxt_idx;
            end else begin
              state   <= FCS;
              mii_txd <= fcs[3:0];
              cnt     <= 8'd1;
            end
`else
            state   <= FCS;
            mii_txd <= fcs[3:0];
            cnt     <= 8'd1;
`endif
          end else begin
            state    <= DATA;
            mii_txd  <= buf_data[3:0];
            hi_nib   <= buf_data[7:4];
            crc      <= crc_nxt;
            hi_phase <= 1'b1;
            byte_idx <= nxt_idx;
            buf_addr <= addr_nxt;
          end
        end

`ifdef ETH_TX_PAD_EN
        PAD: begin
          if (hi_phase) begin
            mii_txd  <= 4'h0;
            hi_phase <= 1'b0;
          end else if (byte_idx == MIN_W) begin
            state   <= FCS;
            mii_txd <= fcs[3:0];
            cnt     <= 8'd1;
          end else begin
            mii_txd  <= 4'h0;
            crc      <= crc_nxt;
            hi_phase <= 1'b1;
            byte_idx <= nxt_idx;
          end
        end
`endif

        // FCS goes out as ~crc, byte 0 first, low nibble first.
        FCS: begin
          if (cnt == 8'd8) begin
            state     <= IFG;
            mii_tx_en <= 1'b0;
            mii_txd   <= 4'h0;
            cnt       <= 8'd1;
          end else begin
            mii_txd <= fcs[{cnt[2:0], 2'b00} +: 4];
            cnt     <= cnt + 8'd1;
          end
        end

        IFG: begin
          if (cnt == IFG_W) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt  <= cnt + 8'd1;
            done <= (cnt == IFG_W - 8'd1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
